// File: rtl/div_issue_queue_pkg.sv
// Shared core types used by the divider issue path: uop and branch records,
// the divide opcode set, and the signed sqN age test.
package div_issue_queue_pkg;

    localparam int SQN_W = 7;
    localparam int TAG_W = 7;

    typedef logic [SQN_W-1:0] SqN;

    typedef enum logic [1:0] {
        DIV_DIV,
        DIV_DIVU,
        DIV_REM,
        DIV_REMU
    } DivOp;

    typedef struct packed {
        logic             valid;
        DivOp             opcode;
        logic [31:0]      srcA;
        logic [31:0]      srcB;
        logic [TAG_W-1:0] tagDst;
        SqN               sqN;
    } EX_UOp;

    typedef struct packed {
        logic taken;
        SqN   sqN;
    } BranchProv;

    // True when 'a' is younger than 'b' in the wrapping sequence space.
    function automatic logic sqn_younger(input SqN a, input SqN b);
        SqN diff;
        diff = a - b;
        return $signed(diff) > 0;
    endfunction

endpackage

// File: rtl/div_issue_queue_if.sv
// Dispatch/branch/divider handshake bundle around the divider issue queue.
interface div_issue_queue_if;
    import div_issue_queue_pkg::*;

    BranchProv IN_branch;
    EX_UOp     IN_uop;
    logic      OUT_ready;
    logic      IN_divBusy;
    logic      OUT_en;
    EX_UOp     OUT_uop;

    modport master (
        output IN_branch, IN_uop, IN_divBusy,
        input  OUT_ready, OUT_en, OUT_uop
    );

    modport slave (
        input  IN_branch, IN_uop, IN_divBusy,
        output OUT_ready, OUT_en, OUT_uop
    );

endinterface

// File: rtl/div_issue_queue.sv
// In-order FIFO between integer dispatch and the iterative divider; issues one
// uop at a time with a post-issue holdoff and drops branch-squashed entries.
module div_issue_queue
    import div_issue_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 3
) (
    input logic              clk,
    input logic              rst,
    div_issue_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(HOLDOFF + 2);

    EX_UOp         mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail_flush;
    logic [PW-1:0] idx;
    logic [CW-1:0] count;
    logic [CW-1:0] kept;
    logic [CW-1:0] count_nxt;
    logic [HW-1:0] holdoff;
    logic          found;
    logic          head_sq;
    logic          in_sq;
    logic          enq;
    logic          issue;

    // Entries are in program order, so the first squashed one from the head
    // marks the start of a contiguous squashed suffix; 'kept' survives.
    always_comb begin
        found      = 1'b0;
        kept       = count;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (!found && (CW'(k) < count) && bus.IN_branch.taken &&
                sqn_younger(mem[idx].sqN, bus.IN_branch.sqN)) begin
                found = 1'b1;
                kept  = CW'(k);
            end
        end
        head_sq    = found && (kept == '0);
        tail_flush = found ? (head + kept[PW-1:0]) : tail;

        bus.OUT_ready = (count < CW'(DEPTH));
        in_sq = bus.IN_branch.taken && sqn_younger(bus.IN_uop.sqN, bus.IN_branch.sqN);
        enq   = bus.IN_uop.valid && bus.OUT_ready && !in_sq;
        issue = (count != '0) && !bus.IN_divBusy && (holdoff == '0) && !head_sq;

        count_nxt = kept + CW'(enq) - CW'(issue);
    end

    assign bus.OUT_en = bus.OUT_uop.valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            holdoff     <= '0;
            bus.OUT_uop <= '0;
        end else begin
            head  <= head + PW'(issue);
            tail  <= tail_flush + PW'(enq);
            count <= count_nxt;

            if (issue)
                holdoff <= HW'(HOLDOFF);
            else if (holdoff != '0)
                holdoff <= holdoff - HW'(1);

            // Output is valid for a single cycle; holdoff guarantees no
            // back-to-back issue, so this also retires a squashed in-flight op.
            if (issue) begin
                bus.OUT_uop       <= mem[head];
                bus.OUT_uop.valid <= 1'b1;
            end else begin
                bus.OUT_uop.valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            mem[tail_flush] <= bus.IN_uop;
    end

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue: stimulus queues expected issues
// (sqN, opcode, cycle) and a negedge monitor pops and compares them.
module tb_div_issue_queue;
    import div_issue_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_issue_queue_if bus ();

    div_issue_queue #(.DEPTH(4), .HOLDOFF(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        SqN   sqn;
        DivOp op;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.OUT_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got sqN=%0d at cycle %0d, required no issue",
                         bus.OUT_uop.sqN, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.OUT_uop.sqN !== e.sqn || bus.OUT_uop.opcode !== e.op || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL issue: got sqN=%0d op=%0d cycle=%0d, required sqN=%0d op=%0d cycle=%0d",
                             bus.OUT_uop.sqN, bus.OUT_uop.opcode, cyc, e.sqn, e.op, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_issue(input int s, input DivOp op, input int c);
        exp_t e;
        e.sqn = SqN'(s);
        e.op  = op;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Presents one uop for a single edge; returns the number of that edge.
    task automatic enq(input int s, input DivOp op, output int edge_cyc);
        bus.IN_uop.valid  = 1'b1;
        bus.IN_uop.opcode = op;
        bus.IN_uop.sqN    = SqN'(s);
        bus.IN_uop.srcA   = 32'(s * 3);
        bus.IN_uop.srcB   = 32'(s + 1);
        bus.IN_uop.tagDst = TAG_W'(s);
        @(posedge clk);
        #1;
        edge_cyc = cyc;
        bus.IN_uop.valid = 1'b0;
    endtask

    task automatic branch(input int s);
        bus.IN_branch.taken = 1'b1;
        bus.IN_branch.sqN   = SqN'(s);
        @(posedge clk);
        #1;
        bus.IN_branch.taken = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int e;
        int x;
        bus.IN_uop     = '0;
        bus.IN_branch  = '0;
        bus.IN_divBusy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_ready", int'(bus.OUT_ready), 1);
        chk("reset_en", int'(bus.OUT_en), 0);
        chk("reset_out_valid", int'(bus.OUT_uop.valid), 0);
        idle(2);

        // basic issue, one cycle after enqueue
        enq(5, DIV_DIV, e);
        expect_issue(5, DIV_DIV, e + 1);
        idle(8);

        // back-to-back enqueue: issues spaced HOLDOFF+1 apart
        enq(1, DIV_DIVU, e);
        expect_issue(1, DIV_DIVU, e + 1);
        enq(2, DIV_REM, x);
        enq(3, DIV_REMU, x);
        expect_issue(2, DIV_REM, e + 5);
        expect_issue(3, DIV_REMU, e + 9);
        idle(14);

        // busy stall for 10 cycles
        bus.IN_divBusy = 1'b1;
        enq(7, DIV_DIV, e);
        repeat (10) @(posedge clk);
        #1 bus.IN_divBusy = 1'b0;
        expect_issue(7, DIV_DIV, e + 11);
        idle(8);

        // full queue refuses the fifth uop
        bus.IN_divBusy = 1'b1;
        enq(30, DIV_DIV, e);
        enq(31, DIV_DIVU, x);
        enq(32, DIV_REM, x);
        enq(33, DIV_REMU, x);
        chk("full_ready_after4", int'(bus.OUT_ready), 0);
        enq(34, DIV_DIV, x);
        chk("full_ready_refused", int'(bus.OUT_ready), 0);
        bus.IN_divBusy = 1'b0;
        expect_issue(30, DIV_DIV, e + 5);
        expect_issue(31, DIV_DIVU, e + 9);
        expect_issue(32, DIV_REM, e + 13);
        expect_issue(33, DIV_REMU, e + 17);
        idle(1);
        chk("full_ready_after_issue", int'(bus.OUT_ready), 1);
        idle(20);

        // flush 12,13 out of 10..13; refill proves count=2 and tail rewound
        bus.IN_divBusy = 1'b1;
        enq(10, DIV_DIV, e);
        enq(11, DIV_DIVU, x);
        enq(12, DIV_REM, x);
        enq(13, DIV_REMU, x);
        branch(11);
        chk("flush_ready", int'(bus.OUT_ready), 1);
        enq(14, DIV_REM, x);
        enq(15, DIV_DIVU, x);
        chk("flush_refill_full", int'(bus.OUT_ready), 0);
        bus.IN_divBusy = 1'b0;
        expect_issue(10, DIV_DIV, e + 7);
        expect_issue(11, DIV_DIVU, e + 11);
        expect_issue(14, DIV_REM, e + 15);
        expect_issue(15, DIV_DIVU, e + 19);
        idle(24);

        // output and head both squashed
        enq(20, DIV_DIV, e);
        expect_issue(20, DIV_DIV, e + 1);
        enq(21, DIV_REM, x);
        branch(19);
        chk("outflush_en", int'(bus.OUT_en), 0);
        chk("outflush_ready", int'(bus.OUT_ready), 1);
        idle(10);
        enq(40, DIV_REMU, e);
        expect_issue(40, DIV_REMU, e + 1);
        idle(8);

        // asynchronous reset mid-operation
        enq(50, DIV_DIV, e);
        enq(51, DIV_DIVU, x);
        chk("midrst_en_before", int'(bus.OUT_en), 1);
        chk("midrst_sqn_before", int'(bus.OUT_uop.sqN), 50);
        rst = 1'b1;
        #1;
        chk("midrst_en_async", int'(bus.OUT_en), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_ready", int'(bus.OUT_ready), 1);
        enq(60, DIV_REM, e);
        expect_issue(60, DIV_REM, e + 1);
        idle(10);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
